// File: rtl/dec_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, ALU operation
// encoding, decoded-control bundle and run/halt state encoding.
package dec_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] BUBBLE_INST = 32'h0000_0033;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic    legal;
        logic    sys;
        logic    use_rs1;
        logic    use_rs2;
        alu_op_t alu_op;
        logic    alu_src;
        logic    branch;
        logic    jal;
        logic    jalr;
        logic    mem_rd;
        logic    mem_wr;
        logic    reg_wr;
    } ctrl_t;

    // funct3 to ALU op for OP-IMM / OP; alt is inst[30]
    function automatic alu_op_t alu_f3(input logic [2:0] f3, input logic alt, input logic is_reg);
        alu_op_t op;
        case (f3)
            3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/dec_imm.sv
// Combinational RV32I immediate generator: selects I/S/B/U/J format from the
// opcode and sign-extends from inst[31]; unknown opcodes yield zero.
module dec_imm
    import dec_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    // Format select by opcode
    always_comb begin
        case (inst[6:0])
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM:
                imm = {{20{inst[31]}}, inst[31:20]};
            OP_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {inst[31:12], 12'h000};
            OP_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dec.sv
// RV32I decode stage: control/immediate decode, regfile read, load-use hold
// and run/halt FSM feeding the ID/EX register. Optional macro
// DEC_WB_BYPASS_EN adds same-cycle writeback forwarding into o_rs1/o_rs2.
module dec
    import dec_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INST = dec_pkg::BUBBLE_INST
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_nxt_pc,
    input  logic        i_vld,
    input  logic        i_flush,
    output logic        o_hold,
    output logic [4:0]  o_rs1_raddr,
    output logic [4:0]  o_rs2_raddr,
    input  logic [31:0] i_rs1_rdata,
    input  logic [31:0] i_rs2_rdata,
`ifdef DEC_WB_BYPASS_EN
    input  logic        i_wb_en,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
`endif
    output logic [31:0] o_rs1,
    output logic [31:0] o_rs2,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rd,
    output logic [3:0]  o_alu_op,
    output logic        o_alu_src,
    output logic [2:0]  o_opsel,
    output logic        o_branch,
    output logic        o_jal,
    output logic        o_jalr,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic        o_reg_wr,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_nxt_pc,
    output logic        o_vld,
    output logic        o_halt
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    ctrl_t       ctrl_s;
    logic [31:0] imm_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic        load_hit_s;
    logic        hold_s;
    logic        bubble_s;
    state_t      state_r;
    state_t      state_nxt_s;

    assign opcode_s    = i_inst[6:0];
    assign funct3_s    = i_inst[14:12];
    assign rs1_s       = i_inst[19:15];
    assign rs2_s       = i_inst[24:20];
    assign o_rs1_raddr = rs1_s;
    assign o_rs2_raddr = rs2_s;

    dec_imm u_imm (
        .inst (i_inst),
        .imm  (imm_s)
    );

    // Opcode-level control decode; only ECALL/EBREAK are legal SYSTEM words
    always_comb begin
        ctrl_s        = '0;
        ctrl_s.alu_op = ALU_ADD;
        case (opcode_s)
            OP_LUI: begin
                ctrl_s.legal   = 1'b1;
                ctrl_s.alu_op  = ALU_PASSB;
                ctrl_s.alu_src = 1'b1;
                ctrl_s.reg_wr  = 1'b1;
            end
            OP_AUIPC: begin
                ctrl_s.legal   = 1'b1;
                ctrl_s.alu_src = 1'b1;
                ctrl_s.reg_wr  = 1'b1;
            end
            OP_JAL: begin
                ctrl_s.legal   = 1'b1;
                ctrl_s.alu_src = 1'b1;
                ctrl_s.jal     = 1'b1;
                ctrl_s.reg_wr  = 1'b1;
            end
            OP_JALR: begin
                ctrl_s.legal   = 1'b1;
                ctrl_s.use_rs1 = 1'b1;
                ctrl_s.alu_src = 1'b1;
                ctrl_s.jalr    = 1'b1;
                ctrl_s.reg_wr  = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_s.legal   = 1'b1;
                ctrl_s.use_rs1 = 1'b1;
                ctrl_s.use_rs2 = 1'b1;
                ctrl_s.alu_op  = ALU_SUB;
                ctrl_s.branch  = 1'b1;
            end
            OP_LOAD: begin
                ctrl_s.legal   = 1'b1;
                ctrl_s.use_rs1 = 1'b1;
                ctrl_s.alu_src = 1'b1;
                ctrl_s.mem_rd  = 1'b1;
                ctrl_s.reg_wr  = 1'b1;
            end
            OP_STORE: begin
                ctrl_s.legal   = 1'b1;
                ctrl_s.use_rs1 = 1'b1;
                ctrl_s.use_rs2 = 1'b1;
                ctrl_s.alu_src = 1'b1;
                ctrl_s.mem_wr  = 1'b1;
            end
            OP_IMM: begin
                ctrl_s.legal   = 1'b1;
                ctrl_s.use_rs1 = 1'b1;
                ctrl_s.alu_op  = alu_f3(funct3_s, i_inst[30], 1'b0);
                ctrl_s.alu_src = 1'b1;
                ctrl_s.reg_wr  = 1'b1;
            end
            OP_REG: begin
                ctrl_s.legal   = 1'b1;
                ctrl_s.use_rs1 = 1'b1;
                ctrl_s.use_rs2 = 1'b1;
                ctrl_s.alu_op  = alu_f3(funct3_s, i_inst[30], 1'b1);
                ctrl_s.reg_wr  = 1'b1;
            end
            OP_SYSTEM: begin
                if ((i_inst == INST_ECALL) || (i_inst == INST_EBREAK)) begin
                    ctrl_s.legal = 1'b1;
                    ctrl_s.sys   = 1'b1;
                end else begin
                    ctrl_s.legal = 1'b0;
                end
            end
            default: ctrl_s.legal = 1'b0;
        endcase
    end

    // Load in ID/EX targets a register this instruction actually reads
    always_comb begin
        if (o_vld && o_mem_rd && (o_rd != 5'd0)) begin
            load_hit_s = (ctrl_s.use_rs1 && (o_rd == rs1_s)) ||
                         (ctrl_s.use_rs2 && (o_rd == rs2_s));
        end else begin
            load_hit_s = 1'b0;
        end
    end

    // Run/halt next state and hold request; flush masks both hold and halt
    always_comb begin
        state_nxt_s = state_r;
        hold_s      = 1'b0;
        case (state_r)
            ST_RUN: begin
                hold_s = i_vld && load_hit_s && !i_flush;
                if (i_vld && !i_flush && !hold_s && ctrl_s.sys) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                hold_s      = 1'b1;
                state_nxt_s = ST_HALTED;
            end
            default: begin
                hold_s      = 1'b0;
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    assign o_hold   = hold_s;
    assign bubble_s = !i_vld || i_flush || hold_s || !ctrl_s.legal;

`ifdef DEC_WB_BYPASS_EN
    // Same-cycle writeback forwarding ahead of the regfile read data
    always_comb begin
        if (i_wb_en && (i_wb_addr != 5'd0) && (i_wb_addr == rs1_s)) begin
            rs1_val_s = i_wb_data;
        end else begin
            rs1_val_s = i_rs1_rdata;
        end
        if (i_wb_en && (i_wb_addr != 5'd0) && (i_wb_addr == rs2_s)) begin
            rs2_val_s = i_wb_data;
        end else begin
            rs2_val_s = i_rs2_rdata;
        end
    end
`else
    assign rs1_val_s = i_rs1_rdata;
    assign rs2_val_s = i_rs2_rdata;
`endif

    // State register; o_halt trails the HALTED state by one cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_RUN;
            o_halt  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            o_halt  <= (state_r == ST_HALTED);
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rs1     <= 32'h0000_0000;
            o_rs2     <= 32'h0000_0000;
            o_imm     <= 32'h0000_0000;
            o_rd      <= 5'd0;
            o_alu_op  <= ALU_ADD;
            o_alu_src <= 1'b0;
            o_opsel   <= 3'd0;
            o_branch  <= 1'b0;
            o_jal     <= 1'b0;
            o_jalr    <= 1'b0;
            o_mem_rd  <= 1'b0;
            o_mem_wr  <= 1'b0;
            o_reg_wr  <= 1'b0;
            o_inst    <= BUBBLE_INST;
            o_pc      <= RESET_PC;
            o_nxt_pc  <= RESET_PC;
            o_vld     <= 1'b0;
        end else begin
            o_rs1     <= rs1_val_s;
            o_rs2     <= rs2_val_s;
            o_imm     <= imm_s;
            o_alu_op  <= ctrl_s.alu_op;
            o_alu_src <= ctrl_s.alu_src;
            o_opsel   <= funct3_s;
            o_pc      <= i_pc;
            o_nxt_pc  <= i_nxt_pc;
            if (bubble_s) begin
                o_rd     <= 5'd0;
                o_branch <= 1'b0;
                o_jal    <= 1'b0;
                o_jalr   <= 1'b0;
                o_mem_rd <= 1'b0;
                o_mem_wr <= 1'b0;
                o_reg_wr <= 1'b0;
                o_inst   <= BUBBLE_INST;
                o_vld    <= 1'b0;
            end else begin
                o_rd     <= ctrl_s.reg_wr ? i_inst[11:7] : 5'd0;
                o_branch <= ctrl_s.branch;
                o_jal    <= ctrl_s.jal;
                o_jalr   <= ctrl_s.jalr;
                o_mem_rd <= ctrl_s.mem_rd;
                o_mem_wr <= ctrl_s.mem_wr;
                o_reg_wr <= ctrl_s.reg_wr;
                o_inst   <= i_inst;
                o_vld    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dec.sv
// Self-checking bench for dec: directed steps plus random instruction streams
// compared against an instruction-level reference model of the decode rules.
`timescale 1ns/1ps
module tb_dec;
    import dec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_inst, i_pc, i_nxt_pc, i_rs1_rdata, i_rs2_rdata;
    logic        i_vld, i_flush;
    logic        o_hold, o_alu_src, o_branch, o_jal, o_jalr, o_mem_rd, o_mem_wr, o_reg_wr;
    logic        o_vld, o_halt;
    logic [4:0]  o_rs1_raddr, o_rs2_raddr, o_rd;
    logic [31:0] o_rs1, o_rs2, o_imm, o_inst, o_pc, o_nxt_pc;
    logic [3:0]  o_alu_op;
    logic [2:0]  o_opsel;
`ifdef DEC_WB_BYPASS_EN
    logic        i_wb_en = 1'b0;
    logic [4:0]  i_wb_addr = 5'd0;
    logic [31:0] i_wb_data = 32'h0000_0000;
`endif

    always #5 clk = ~clk;

    dec dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_inst(i_inst), .i_pc(i_pc), .i_nxt_pc(i_nxt_pc),
        .i_vld(i_vld), .i_flush(i_flush), .o_hold(o_hold),
        .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr),
        .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata),
`ifdef DEC_WB_BYPASS_EN
        .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
`endif
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm), .o_rd(o_rd), .o_alu_op(o_alu_op),
        .o_alu_src(o_alu_src), .o_opsel(o_opsel), .o_branch(o_branch), .o_jal(o_jal),
        .o_jalr(o_jalr), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_reg_wr(o_reg_wr),
        .o_inst(o_inst), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc), .o_vld(o_vld), .o_halt(o_halt)
    );

    typedef struct packed {
        logic        legal, sys, use1, use2;
        logic [3:0]  alu;
        logic        src, br, jal, jalr, mrd, mwr, wr;
        logic [31:0] imm;
    } exp_t;

    localparam alu_op_t F3_OP [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                      ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] regs [32];
    logic        m_vld, m_mrd, m_halted;
    logic [4:0]  m_rd;
    logic        h;
    logic [31:0] cur, pc;
    logic        v, f;

    // Reference decode: instruction word -> expected ID/EX contents
    function automatic exp_t ref_dec(input logic [31:0] w);
        exp_t e;
        int   b;
        logic [6:0] op;
        logic [2:0] f3;
        e  = '0;
        op = w[6:0];
        f3 = w[14:12];
        e.legal = (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                              OP_STORE, OP_IMM, OP_REG}) ||
                  ((op == OP_SYSTEM) && ((w == 32'h0000_0073) || (w == 32'h0010_0073)));
        e.sys  = e.legal && (op == OP_SYSTEM);
        e.use1 = e.legal && !(op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM});
        e.use2 = op inside {OP_REG, OP_STORE, OP_BRANCH};
        e.wr   = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG};
        e.src  = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE, OP_IMM};
        e.br   = (op == OP_BRANCH);
        e.jal  = (op == OP_JAL);
        e.jalr = (op == OP_JALR);
        e.mrd  = (op == OP_LOAD);
        e.mwr  = (op == OP_STORE);
        e.alu  = ALU_ADD;
        if (op == OP_LUI) e.alu = ALU_PASSB;
        else if (op == OP_BRANCH) e.alu = ALU_SUB;
        else if (op == OP_IMM || op == OP_REG) begin
            e.alu = F3_OP[f3];
            if (f3 == 3'd5 && w[30]) e.alu = ALU_SRA;
            else if (f3 == 3'd0 && w[30] && op == OP_REG) e.alu = ALU_SUB;
        end
        if (op inside {OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM})
            e.imm = 32'($signed(w) >>> 20);
        else if (op == OP_STORE)
            e.imm = (32'($signed(w) >>> 20) & 32'hFFFF_FFE0) | {27'd0, w[11:7]};
        else if (op == OP_BRANCH) begin
            b = (w[31] ? -4096 : 0) + 2048 * int'(w[7]) + 32 * int'(w[30:25]) + 2 * int'(w[11:8]);
            e.imm = 32'(b);
        end else if (op == OP_JAL) begin
            b = (w[31] ? -1048576 : 0) + 4096 * int'(w[19:12]) + 2048 * int'(w[20]) +
                2 * int'(w[30:21]);
            e.imm = 32'(b);
        end else if (op inside {OP_LUI, OP_AUIPC})
            e.imm = w & 32'hFFFF_F000;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_vld = 1'b0; m_mrd = 1'b0; m_rd = 5'd0; m_halted = 1'b0;
    endtask

    // One decode cycle: drive at negedge, check hold, then check ID/EX after the edge
    task automatic step(input logic [31:0] w, input logic [31:0] p, input logic vl,
                        input logic fl, output logic hold_exp);
        exp_t e;
        logic hz, bub;
        logic [31:0] x1, x2;
        @(negedge clk);
        i_inst = w; i_pc = p; i_nxt_pc = p + 32'd4; i_vld = vl; i_flush = fl;
        i_rs1_rdata = regs[w[19:15]];
        i_rs2_rdata = regs[w[24:20]];
        x1 = regs[w[19:15]];
        x2 = regs[w[24:20]];
`ifdef DEC_WB_BYPASS_EN
        if (i_wb_en && i_wb_addr != 5'd0 && i_wb_addr == w[19:15]) x1 = i_wb_data;
        if (i_wb_en && i_wb_addr != 5'd0 && i_wb_addr == w[24:20]) x2 = i_wb_data;
`endif
        e   = ref_dec(w);
        hz  = !m_halted && vl && !fl && m_vld && m_mrd && (m_rd != 5'd0) &&
              ((e.use1 && m_rd == w[19:15]) || (e.use2 && m_rd == w[24:20]));
        hold_exp = m_halted || hz;
        bub = hold_exp || !vl || fl || !e.legal;
        #1;
        chk("hold", 32'(o_hold), 32'(hold_exp));
        chk("rs1_raddr", 32'(o_rs1_raddr), 32'(w[19:15]));
        chk("rs2_raddr", 32'(o_rs2_raddr), 32'(w[24:20]));
        @(posedge clk);
        #1;
        chk("vld", 32'(o_vld), 32'(!bub));
        chk("inst", o_inst, bub ? 32'h0000_0033 : w);
        chk("halt", 32'(o_halt), 32'(m_halted));
        chk("ctl", {25'd0, o_branch, o_jal, o_jalr, o_mem_rd, o_mem_wr, o_reg_wr, o_vld},
            bub ? 32'd0 : {25'd0, e.br, e.jal, e.jalr, e.mrd, e.mwr, e.wr, 1'b1});
        if (!bub) begin
            chk("imm", o_imm, e.imm);
            chk("rd", 32'(o_rd), e.wr ? 32'(w[11:7]) : 32'd0);
            chk("alu_op", 32'(o_alu_op), 32'(e.alu));
            chk("alu_src", 32'(o_alu_src), 32'(e.src));
            chk("opsel", 32'(o_opsel), 32'(w[14:12]));
            chk("rs1", o_rs1, x1);
            chk("rs2", o_rs2, x2);
            chk("pc", o_pc, p);
            chk("nxt_pc", o_nxt_pc, p + 32'd4);
        end
        m_halted = m_halted || (!bub && e.sys);
        m_vld    = !bub;
        m_mrd    = !bub && e.mrd;
        m_rd     = (bub || !e.wr) ? 5'd0 : w[11:7];
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom_range(0, 13))
            0: op = OP_LUI;     1: op = OP_AUIPC;  2: op = OP_JAL;    3: op = OP_JALR;
            4: op = OP_BRANCH;  5: op = OP_LOAD;   6: op = OP_LOAD;   7: op = OP_STORE;
            8: op = OP_IMM;     9: op = OP_REG;    10: op = OP_REG;   11: op = 7'h0F;
            12: op = 7'h7F;     default: op = OP_LOAD;
        endcase
        r[6:0]   = op;
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'h0000_0000;
        i_inst = 32'h0000_0033; i_pc = 32'd0; i_nxt_pc = 32'd4; i_vld = 1'b0; i_flush = 1'b0;
        i_rs1_rdata = 32'd0; i_rs2_rdata = 32'd0;
        reset_model();
        #12;
        chk("rst_vld", 32'(o_vld), 32'd0);
        chk("rst_inst", o_inst, 32'h0000_0033);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_nxt_pc", o_nxt_pc, 32'd0);
        chk("rst_halt", 32'(o_halt), 32'd0);
        chk("rst_hold", 32'(o_hold), 32'd0);
        chk("rst_imm_rd", o_imm | 32'(o_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h0000_0033, 32'd0, 1'b0, 1'b0, h);

        // ADDI x5,x0,-1
        step(32'hFFF0_0293, 32'h10, 1'b1, 1'b0, h);
        chk("addi_imm", o_imm, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(o_rd), 32'd5);
        chk("addi_src_wr", {30'd0, o_alu_src, o_reg_wr}, 32'd3);
        chk("addi_pc", o_pc, 32'h10);

        // LW x6,0(x1) then ADD x7,x6,x2: single-cycle hold with bubble
        step(32'h0000_A303, 32'h20, 1'b1, 1'b0, h);
        step(32'h0023_03B3, 32'h24, 1'b1, 1'b0, h);
        chk("lu_bubble", 32'(o_vld), 32'd0);
        chk("lu_hold_drop", 32'(o_hold), 32'd0);
        step(32'h0023_03B3, 32'h24, 1'b1, 1'b0, h);
        chk("lu_reissue", 32'(o_vld), 32'd1);
        // LW x0 then ADD x7,x0,x2: no hold
        step(32'h0000_A003, 32'h28, 1'b1, 1'b0, h);
        step(32'h0020_03B3, 32'h2C, 1'b1, 1'b0, h);
        // Hazard plus flush: no hold, bubble, no later stall
        step(32'h0000_A303, 32'h30, 1'b1, 1'b0, h);
        step(32'h0023_03B3, 32'h34, 1'b1, 1'b1, h);
        chk("flush_bubble", 32'(o_vld), 32'd0);
        step(32'h0023_03B3, 32'h38, 1'b1, 1'b0, h);

`ifdef DEC_WB_BYPASS_EN
        regs[3] = 32'h1111_1111;
        i_wb_en = 1'b1; i_wb_addr = 5'd3; i_wb_data = 32'hDEAD_BEEF;
        step(32'h0031_80B3, 32'h3C, 1'b1, 1'b0, h);
        chk("byp_rs1", o_rs1, 32'hDEAD_BEEF);
        chk("byp_rs2", o_rs2, 32'hDEAD_BEEF);
        i_wb_en = 1'b0;
`endif

        // Random stream; a held instruction is re-presented as fetch is frozen
        h = 1'b0; cur = 32'h0000_0033; pc = 32'h100; v = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!h) begin
                cur = gen_inst();
                pc  = {$urandom_range(0, 32'h3FFF), 2'b00};
                v   = ($urandom_range(0, 9) != 0);
            end
            f = ($urandom_range(0, 9) == 0);
            step(cur, pc, v, f, h);
        end

        // EBREAK: valid in ID/EX, then halted with permanent hold
        step(32'h0000_0033, 32'h200, 1'b0, 1'b0, h);
        step(32'h0010_0073, 32'h204, 1'b1, 1'b0, h);
        chk("ebreak_vld", 32'(o_vld), 32'd1);
        chk("ebreak_hold", 32'(o_hold), 32'd1);
        for (int k = 0; k < 4; k++) step(32'hFFF0_0293, 32'h208, 1'b1, 1'b0, h);
        chk("halted", 32'(o_halt), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_halt", 32'(o_halt), 32'd0);
        chk("rst_mid_hold", 32'(o_hold), 32'd0);
        chk("rst_mid_vld", 32'(o_vld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        step(32'hFFF0_0293, 32'h10, 1'b1, 1'b0, h);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dec.md
Name: dec

Overview:
- RV32I decode stage, directly downstream of the fetch stage's IF/ID register.
- Consumes the fetched instruction, its PC, next-PC and valid bit.
- Decodes control fields and the immediate, reads the register file, and detects load-use hazards, raising a hold back to fetch.
- Drives the ID/EX pipeline register consumed by execute. A small run/halt state machine latches EBREAK/ECALL.

Parameters:
- RESET_PC, 32'h00000000, reset value of o_pc and o_nxt_pc.
- BUBBLE_INST, 32'h00000033, instruction word loaded into o_inst on a bubble (add x0,x0,x0).

Ports:
- i_clk  in  1  global clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_inst  in  32  instruction from IF/ID.
- i_pc  in  32  PC of i_inst.
- i_nxt_pc  in  32  PC+4 / predicted next PC of i_inst.
- i_vld  in  1  i_inst valid.
- i_flush  in  1  redirect from fetch; kill the instruction in ID.
- o_hold  out  1  combinational stall request to fetch (IF/ID and PC freeze).
- o_rs1_raddr  out  5  regfile read address 1, combinational from i_inst[19:15].
- o_rs2_raddr  out  5  regfile read address 2, from i_inst[24:20].
- i_rs1_rdata  in  32  regfile read data 1, same cycle.
- i_rs2_rdata  in  32  regfile read data 2, same cycle.
- o_rs1  out  32  registered rs1 value.
- o_rs2  out  32  registered rs2 value.
- o_imm  out  32  registered sign-extended immediate.
- o_rd  out  5  registered destination register.
- o_alu_op  out  4  registered ALU operation (package enum).
- o_alu_src  out  1  registered: 1 = immediate operand B.
- o_opsel  out  3  registered funct3 (branch/load/store size).
- o_branch, o_jal, o_jalr, o_mem_rd, o_mem_wr, o_reg_wr  out  1 each  registered controls.
- o_inst, o_pc, o_nxt_pc  out  32 each  registered pass-through.
- o_vld  out  1  registered valid.
- o_halt  out  1  registered; processor halted.

Behaviour:
- Reset (i_rst_n=0, async):
  - all controls, o_vld and o_halt = 0; o_rs1/o_rs2/o_imm = 0; o_rd = 0.
  - o_inst = BUBBLE_INST; o_pc = o_nxt_pc = RESET_PC; state = RUN.
- Latency: one cycle, ID to ID/EX register.
- Immediate: I/S/B/U/J formats per opcode. B/J have bit 0 = 0, sign-extended from inst[31]. U is inst[31:12] << 12.
- Valid-qualified use:
  - rs1 is used by all opcodes except LUI, AUIPC, JAL.
  - rs2 is used by R, S, B only.
  - A register x0 is never a hazard.
- Hazard (o_hold = 1) when all hold: i_vld; o_vld && o_mem_rd && o_rd != 0; and o_rd equals a used rs; and !i_flush; and state == RUN.
- On a hold cycle, ID/EX loads a bubble: o_vld = 0, all write/mem/branch/jump controls = 0, o_inst = BUBBLE_INST.
  - The next cycle re-decodes the same i_inst (fetch held), so the hold lasts exactly 1 cycle.
- Flush: i_flush takes priority over the hold and over halt detection. ID/EX loads a bubble; o_hold = 0.
- Illegal or unknown opcode: decoded as a bubble (o_vld = 0); no trap.
- State machine: RUN -> HALTED when a valid, non-flushed EBREAK or ECALL is latched into ID/EX.
  - In that same edge, o_vld = 1 for that instruction, then o_halt = 1 from the following cycle.
- HALTED:
  - o_halt = 1 and o_hold = 1 constantly.
  - ID/EX loads bubbles every cycle.
  - Leaves HALTED only on reset.
- Reset mid-hold or mid-halt: state = RUN immediately; o_hold drops as soon as o_vld clears.

Optional Feature:
- Macro DEC_WB_BYPASS_EN adds inputs i_wb_en (1), i_wb_addr (5) and i_wb_data (32).
- With the macro: if i_wb_en && i_wb_addr != 0 && i_wb_addr == rsN address, o_rsN is latched from i_wb_data instead of i_rsN_rdata (same-cycle writeback forwarding).
- Without the macro: no ports are added; the regfile is relied on for write-before-read.

Decomposition:
- Package dec_pkg holds:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM);
  - alu_op_t 4-bit enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB);
  - the BUBBLE_INST constant.
- One sub-module, dec_imm: a purely combinational immediate generator (inst -> imm).

Test Plan:
- Reset, then release with i_vld = 0 -> o_vld = 0, o_inst = 32'h00000033, o_pc = 0, o_halt = 0, o_hold = 0.
- ADDI x5,x0,-1 (32'hFFF00293), pc = 0x10, valid -> next cycle: o_imm = 32'hFFFFFFFF, o_rd = 5, o_alu_src = 1, o_reg_wr = 1, o_pc = 0x10, o_vld = 1.
- LW x6,0(x1), then ADD x7,x6,x2 -> o_hold = 1 for exactly 1 cycle and a bubble (o_vld = 0) is inserted. Repeat with x0 as the load rd -> no hold.
- Load-use hazard condition plus i_flush in the same cycle -> o_hold = 0, ID/EX bubble, no second-cycle stall.
- EBREAK (32'h00100073) valid -> ID/EX o_vld = 1 for it, o_halt = 1 next cycle, o_hold stays 1. Pulse i_rst_n low mid-halt -> o_halt = 0 immediately (async).
- With DEC_WB_BYPASS_EN: i_wb_en = 1, addr = 3, data = 0xDEADBEEF while decoding ADD x1,x3,x3 with stale regfile data -> o_rs1 = o_rs2 = 0xDEADBEEF.
